// File: rtl/calc_pkg.sv
// Shared definitions for the calculator key-entry block: key codes, FSM states,
// operand width and key classification helpers.
package calc_pkg;

  localparam int BCD_W = 16;

  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_MUL = 4'hC;
  localparam logic [3:0] KEY_DIV = 4'hD;
  localparam logic [3:0] KEY_CLR = 4'hE;
  localparam logic [3:0] KEY_EQ  = 4'hF;

  typedef enum logic [2:0] {
    S_NUM1,
    S_OP,
    S_NUM2,
    S_WAIT,
    S_RESULT
  } state_t;

  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'h9;
  endfunction

  function automatic logic is_op(input logic [3:0] k);
    return (k >= KEY_ADD) && (k <= KEY_DIV);
  endfunction

endpackage

// File: rtl/calc_key_entry_if.sv
// Keypad strobe, ALU handshake and display bus of the key-entry block.
// master = key-entry block side, slave = keypad/ALU/display environment side.
interface calc_key_entry_if
  import calc_pkg::*;
  ();
  logic [3:0]       key_code;
  logic             key_valid;
  logic [BCD_W-1:0] alu_num1;
  logic [BCD_W-1:0] alu_num2;
  logic [3:0]       alu_op;
  logic             alu_start;
  logic [BCD_W-1:0] alu_res;
  logic             alu_done;
  logic [BCD_W-1:0] display;
  logic             error;

  modport master (
    input  key_code, key_valid, alu_res, alu_done,
    output alu_num1, alu_num2, alu_op, alu_start, display, error
  );

  modport slave (
    output key_code, key_valid, alu_res, alu_done,
    input  alu_num1, alu_num2, alu_op, alu_start, display, error
  );
endinterface

// File: rtl/bcd_operand_reg.sv
// One BCD operand: left-shifting digit register with a digit counter that skips
// leading zeros and stops accepting digits once MAX_DIGITS are held.
module bcd_operand_reg
  import calc_pkg::*;
#(
  parameter int MAX_DIGITS = 4,
  localparam int CW = $clog2(MAX_DIGITS + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr,
  input  logic             load,
  input  logic [BCD_W-1:0] load_val,
  input  logic [CW-1:0]    load_cnt,
  input  logic             digit_en,
  input  logic [3:0]       digit,
  output logic [BCD_W-1:0] value,
  output logic [CW-1:0]    cnt
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      value <= '0;
      cnt   <= '0;
    end else if (clr) begin
      value <= '0;
      cnt   <= '0;
    end else if (load) begin
      value <= load_val;
      cnt   <= load_cnt;
    end else if (digit_en && (cnt != CW'(MAX_DIGITS))) begin
      value <= {value[BCD_W-5:0], digit};
      // A zero typed into an empty operand does not use up a digit slot
      if (!((cnt == '0) && (digit == 4'h0)))
        cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/calc_key_entry.sv
// Calculator key-entry FSM: assembles two BCD operands and an operator from key
// strobes, runs a start/done transaction with the ALU and selects the display value.
module calc_key_entry
  import calc_pkg::*;
#(
  parameter int MAX_DIGITS  = 4,
  parameter int ALU_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              resetn,
  calc_key_entry_if.master  bus
);

  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam int TW = $clog2(ALU_TIMEOUT + 1);

  state_t        state, state_nxt;
  logic [3:0]    op, op_nxt;
  logic          start, start_nxt;
  logic          err, err_nxt;
  logic          show2, show2_nxt;
  logic [TW-1:0] tcnt, tcnt_nxt;

  logic             n1_clr, n1_load, n1_dig, n2_clr, n2_load, n2_dig;
  logic [BCD_W-1:0] n1_val, n2_val, num1, num2;
  logic [CW-1:0]    n1_cnt, n2_cnt, cnt1, cnt2;

  logic       kv;
  logic [3:0] key;
  assign kv  = bus.key_valid;
  assign key = bus.key_code;

  bcd_operand_reg #(.MAX_DIGITS(MAX_DIGITS)) u_num1 (
    .clk(clk), .resetn(resetn), .clr(n1_clr), .load(n1_load), .load_val(n1_val),
    .load_cnt(n1_cnt), .digit_en(n1_dig), .digit(key), .value(num1), .cnt(cnt1)
  );

  bcd_operand_reg #(.MAX_DIGITS(MAX_DIGITS)) u_num2 (
    .clk(clk), .resetn(resetn), .clr(n2_clr), .load(n2_load), .load_val(n2_val),
    .load_cnt(n2_cnt), .digit_en(n2_dig), .digit(key), .value(num2), .cnt(cnt2)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_NUM1;
      op    <= '0;
      start <= 1'b0;
      err   <= 1'b0;
      show2 <= 1'b0;
      tcnt  <= '0;
    end else begin
      state <= state_nxt;
      op    <= op_nxt;
      start <= start_nxt;
      err   <= err_nxt;
      show2 <= show2_nxt;
      tcnt  <= tcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    op_nxt    = op;
    start_nxt = 1'b0;
    err_nxt   = err;
    show2_nxt = show2;
    tcnt_nxt  = tcnt;
    n1_clr = 1'b0; n1_load = 1'b0; n1_dig = 1'b0; n1_val = '0; n1_cnt = '0;
    n2_clr = 1'b0; n2_load = 1'b0; n2_dig = 1'b0; n2_val = '0; n2_cnt = '0;

    // Clear outranks everything, including an ALU completion in the same cycle
    if (kv && (key == KEY_CLR)) begin
      n1_clr    = 1'b1;
      n2_clr    = 1'b1;
      op_nxt    = '0;
      err_nxt   = 1'b0;
      show2_nxt = 1'b0;
      tcnt_nxt  = '0;
      state_nxt = S_NUM1;
    end else begin
      unique case (state)
        S_NUM1: begin
          if (kv && is_digit(key)) begin
            n1_dig    = 1'b1;
            show2_nxt = 1'b0;
          end else if (kv && is_op(key)) begin
            op_nxt    = key;
            state_nxt = S_OP;
          end
        end
        S_OP: begin
          if (kv && is_op(key)) begin
            op_nxt = key;
          end else if (kv && is_digit(key)) begin
            n2_load   = 1'b1;
            n2_val    = {{(BCD_W-4){1'b0}}, key};
            n2_cnt    = (key == 4'h0) ? CW'(0) : CW'(1);
            show2_nxt = 1'b1;
            state_nxt = S_NUM2;
          end
        end
        S_NUM2: begin
          if (kv && is_digit(key)) begin
            n2_dig = 1'b1;
          end else if (kv && (key == KEY_EQ)) begin
            start_nxt = 1'b1;
            tcnt_nxt  = '0;
            state_nxt = S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.alu_done) begin
            n1_load   = 1'b1;
            n1_val    = bus.alu_res;
            n1_cnt    = CW'(MAX_DIGITS);
            show2_nxt = 1'b0;
            state_nxt = S_RESULT;
          end else if (tcnt == TW'(ALU_TIMEOUT)) begin
            n1_load   = 1'b1;
            err_nxt   = 1'b1;
            show2_nxt = 1'b0;
            state_nxt = S_RESULT;
          end else begin
            tcnt_nxt = tcnt + TW'(1);
          end
        end
        S_RESULT: begin
          if (kv && is_digit(key)) begin
            n1_load   = 1'b1;
            n1_val    = {{(BCD_W-4){1'b0}}, key};
            n1_cnt    = (key == 4'h0) ? CW'(0) : CW'(1);
            n2_clr    = 1'b1;
            err_nxt   = 1'b0;
            show2_nxt = 1'b0;
            state_nxt = S_NUM1;
          end else if (kv && is_op(key)) begin
            op_nxt    = key;
            state_nxt = S_OP;
          end
        end
        default: state_nxt = S_NUM1;
      endcase
    end
  end

  assign bus.alu_num1  = num1;
  assign bus.alu_num2  = num2;
  assign bus.alu_op    = op;
  assign bus.alu_start = start;
  assign bus.error     = err;
  assign bus.display   = show2 ? num2 : num1;

endmodule

// File: tb/tb_calc_key_entry.sv
// Directed bench for calc_key_entry: operand entry, ALU handshake, chaining,
// timeout, clear/done races and asynchronous reset.
module tb_calc_key_entry;
  import calc_pkg::*;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   starts = 0;
  int   base;

  always #5 clk = ~clk;

  calc_key_entry_if bus ();

  calc_key_entry #(.MAX_DIGITS(4), .ALU_TIMEOUT(255)) dut (
    .clk(clk), .resetn(resetn), .bus(bus.master)
  );

  always @(posedge clk) if (bus.alu_start === 1'b1) starts <= starts + 1;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [3:0] k);
    @(negedge clk);
    bus.key_code  = k;
    bus.key_valid = 1'b1;
    @(negedge clk);
    bus.key_valid = 1'b0;
  endtask

  task automatic alu_reply(input logic [15:0] res);
    bus.alu_res  = res;
    bus.alu_done = 1'b1;
    @(negedge clk);
    bus.alu_done = 1'b0;
  endtask

  initial begin
    bus.key_code = 4'h0; bus.key_valid = 1'b0; bus.alu_res = '0; bus.alu_done = 1'b0;
    #2 resetn = 1'b0;
    #1;
    check("rst_display", bus.display, 16'h0000);
    check("rst_num1", bus.alu_num1, 16'h0000);
    check("rst_num2", bus.alu_num2, 16'h0000);
    check("rst_op", {12'h0, bus.alu_op}, 16'h0000);
    check("rst_start_err", {14'h0, bus.alu_start, bus.error}, 16'h0000);
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    // 12 + 34 = 46
    press(4'h1); press(4'h2);
    check("n1_display", bus.display, 16'h0012);
    press(KEY_ADD);
    check("op_add", {12'h0, bus.alu_op}, 16'h000A);
    press(4'h3);
    check("n2_first", bus.display, 16'h0003);
    press(4'h4);
    check("n2_display", bus.display, 16'h0034);
    base = starts;
    press(KEY_EQ);
    check("start_high", {15'h0, bus.alu_start}, 16'h0001);
    check("num1_at_start", bus.alu_num1, 16'h0012);
    check("num2_at_start", bus.alu_num2, 16'h0034);
    check("op_at_start", {12'h0, bus.alu_op}, 16'h000A);
    @(negedge clk);
    check("start_one_cycle", {15'h0, bus.alu_start}, 16'h0000);
    @(negedge clk);
    alu_reply(16'h0046);
    check("result_display", bus.display, 16'h0046);
    check("single_start", 16'(starts - base), 16'h0001);

    // chaining 46 * 2
    press(KEY_MUL); press(4'h2); press(KEY_EQ);
    check("chain_num1", bus.alu_num1, 16'h0046);
    check("chain_op", {12'h0, bus.alu_op}, 16'h000C);
    check("chain_num2", bus.alu_num2, 16'h0002);
    alu_reply(16'h0092);
    check("chain_result", bus.display, 16'h0092);

    // digit limit and leading zeros
    press(KEY_CLR);
    check("clr_display", bus.display, 16'h0000);
    check("clr_op", {12'h0, bus.alu_op}, 16'h0000);
    press(4'h9); press(4'h8); press(4'h7); press(4'h6);
    check("four_digits", bus.display, 16'h9876);
    press(4'h5);
    check("fifth_ignored", bus.display, 16'h9876);
    press(KEY_CLR);
    press(4'h0); press(4'h0); press(4'h7);
    check("leading_zeros", bus.display, 16'h0007);
    press(4'h1); press(4'h2); press(4'h3);
    check("lz_count_one", bus.display, 16'h7123);
    press(4'h4);
    check("lz_full", bus.display, 16'h7123);

    // operator replacement, then timeout
    press(KEY_CLR);
    press(4'h5); press(KEY_ADD); press(KEY_SUB); press(4'h2); press(KEY_EQ);
    check("op_replaced", {12'h0, bus.alu_op}, 16'h000B);
    check("sub_num1", bus.alu_num1, 16'h0005);
    repeat (255) @(negedge clk);
    check("no_err_before_to", {15'h0, bus.error}, 16'h0000);
    @(negedge clk);
    check("err_at_to", {15'h0, bus.error}, 16'h0001);
    check("to_display", bus.display, 16'h0000);
    check("to_num1", bus.alu_num1, 16'h0000);
    press(4'h3);
    check("err_cleared", {15'h0, bus.error}, 16'h0000);
    check("digit_after_to", bus.display, 16'h0003);
    alu_reply(16'h0055);
    check("stray_done", bus.display, 16'h0003);

    // clear while waiting, late done ignored
    press(KEY_ADD); press(4'h4); press(KEY_EQ);
    press(KEY_CLR);
    alu_reply(16'h0099);
    check("clr_wait_display", bus.display, 16'h0000);
    check("clr_wait_num1", bus.alu_num1, 16'h0000);
    press(4'h2); press(4'h3);
    check("after_clr_wait", bus.display, 16'h0023);

    // clear and done on the same edge
    press(KEY_ADD); press(4'h1); press(KEY_EQ);
    @(negedge clk);
    bus.key_code = KEY_CLR; bus.key_valid = 1'b1;
    alu_reply(16'h0099);
    bus.key_valid = 1'b0;
    check("clr_beats_done", bus.display, 16'h0000);

    // done on the timeout edge
    press(4'h1); press(KEY_ADD); press(4'h1); press(KEY_EQ);
    repeat (255) @(negedge clk);
    alu_reply(16'h0002);
    check("done_beats_to_err", {15'h0, bus.error}, 16'h0000);
    check("done_beats_to_disp", bus.display, 16'h0002);

    // asynchronous reset mid-entry
    press(KEY_CLR);
    press(4'h1); press(4'h2); press(KEY_ADD); press(4'h3);
    #2 resetn = 1'b0;
    #1;
    check("arst_display", bus.display, 16'h0000);
    check("arst_num1", bus.alu_num1, 16'h0000);
    check("arst_op", {12'h0, bus.alu_op}, 16'h0000);
    @(negedge clk);
    resetn = 1'b1;
    base = starts;
    press(KEY_EQ);
    repeat (4) @(negedge clk);
    check("no_start_after_rst", 16'(starts - base), 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/calc_key_entry.md
# calc_key_entry

Receiving end of the keypad handshake in the FPGA calculator: consumes the one-cycle key strobe and 4-bit key code from the keypad scanner and assembles them into operands and an operator. Issues a start/done transaction to the ALU and presents the operand being entered, or the result, to the display path. Sits between the keypad controller and the ALU and BCD/7-segment chain.

## Interface

Parameters:
- `MAX_DIGITS`, default 4: BCD digits per operand (16-bit BCD word).
- `ALU_TIMEOUT`, default 255: cycles to wait for `alu_done` before flagging an error.

Ports:
- Clocking: one clock; reset is asynchronous and active-low.
- `clk` in 1: system clock.
- `resetn` in 1: asynchronous active-low reset.
- `key_code` in 4: key code, valid only with `key_valid`.
  - 0x0–0x9: digits.
  - 0xA: add. 0xB: sub. 0xC: mul. 0xD: div.
  - 0xE: clear. 0xF: equals.
- `key_valid` in 1: one-cycle strobe, at most one per key press.
- `alu_num1` out 16: BCD operand 1.
- `alu_num2` out 16: BCD operand 2.
- `alu_op` out 4: operator code, 0xA–0xD.
- `alu_start` out 1: one-cycle request pulse.
- `alu_res` in 16: BCD result, valid with `alu_done`.
- `alu_done` in 1: one-cycle completion pulse.
- `display` out 16: BCD value to show.
- `error` out 1: set by timeout, cleared by the next digit or clear key.

## Operation

States: `S_NUM1`, `S_OP`, `S_NUM2`, `S_WAIT`, `S_RESULT`. Reset state is `S_NUM1`.

Digit entry (`S_NUM1`, `S_NUM2`):
- Operand becomes `{operand[11:0], digit}`.
- The digit counter increments, except for a leading 0 while the count is 0.
- When the count equals `MAX_DIGITS`, further digits are ignored.

Per-state behaviour:
- `S_NUM1`:
  - Digit: entry into num1; display = num1.
  - Operator: latch `alu_op`, go to `S_OP`.
  - Equals: ignored.
- `S_OP`:
  - Operator: replaces `alu_op`.
  - Digit: num2 = digit, count = 1 (0 if the digit is 0), go to `S_NUM2`; display = num2.
  - Equals: ignored.
- `S_NUM2`:
  - Digit: entry into num2.
  - Operator: ignored; no chaining before equals.
  - Equals: pulse `alu_start`, go to `S_WAIT`.
- `S_WAIT`:
  - All keys except clear are ignored.
  - `alu_done`: display = `alu_res`, num1 = `alu_res`, go to `S_RESULT`.
  - Timeout counter reaches `ALU_TIMEOUT`: `error` = 1, display = 0, num1 = 0, go to `S_RESULT`.
- `S_RESULT`:
  - Digit: num1 = digit, num2 = 0, `error` = 0, go to `S_NUM1`.
  - Operator: keep num1 (result chaining), latch op, go to `S_OP`.
  - Equals: ignored.
- Clear, in any state: num1 = num2 = 0, `alu_op` = 0, counters = 0, `error` = 0, display = 0, go to `S_NUM1`. An `alu_done` arriving later is ignored.

## Timing

- Reset values: every output is 0, state is `S_NUM1`, counters are 0.
- Keys are sampled on the rising edge where `key_valid` = 1. Effects on the outputs and state are visible on the next cycle (1-cycle latency).
- `alu_start` rises the cycle after equals is sampled and is high for exactly one cycle.
- `alu_num1`, `alu_num2` and `alu_op` are stable from `alu_start` until `S_WAIT` is left.
- The timeout counter starts at 0 in the cycle `alu_start` is high. It increments every cycle in `S_WAIT`, and the timeout fires when it equals `ALU_TIMEOUT`.
- `alu_done` in the same cycle as the timeout: `alu_done` wins, and `error` stays 0.
- `key_valid` with clear in the same cycle as `alu_done`: clear wins, and the result is discarded.
- `alu_done` outside `S_WAIT` is ignored.
- Reset asserted mid-operation: immediate return to reset values. No `alu_start` is emitted afterwards until a new equals key.

## Structure

- `calc_pkg` shared package:
  - key code constants (`KEY_ADD` … `KEY_EQ`, `KEY_CLR`);
  - the state enum;
  - a `BCD_W = 16` localparam.
- One sub-module, `bcd_operand_reg`, instantiated twice (num1, num2). It contains:
  - the 4-digit BCD shift register;
  - the digit counter with leading-zero and full rules;
  - load/clear inputs.
- The FSM, timeout counter and ALU handshake stay in `calc_key_entry`.

## Test plan

- Keys 1,2,+,3,4,= with `alu_done` 3 cycles after `alu_start`, `alu_res` = 0x0046.
  - Expect `alu_num1` = 0x0012, `alu_num2` = 0x0034, `alu_op` = 0xA.
  - Expect exactly one `alu_start` pulse, then display = 0x0046.
- Keys 9,8,7,6,5: num1 and display = 0x9876, the fifth digit is ignored. Keys 0,0,7: display = 0x0007 with count 1.
- Keys 5,+,−,2,=: `alu_op` = 0xB (operator replaced).
- After result 0x0046, keys *,2,=: `alu_num1` = 0x0046, `alu_op` = 0xC (chaining).
- Equals with no `alu_done`:
  - after `ALU_TIMEOUT` cycles, `error` = 1 and display = 0;
  - then key 3: `error` = 0, display = 0x0003.
- Clear in `S_WAIT`, followed by `alu_done` with 0x0099: display stays 0, state `S_NUM1`. Also assert `resetn` low mid-entry: all outputs go to 0 asynchronously.
